bmp_pixel_loader: RTL and testbench
===================================

Name: bmp_pixel_loader

Overview:
- Sits between data_io (ioctl byte stream) and SDRAM port 1 of the MENU core's background-image path.
- Parses the BMP header and unpacks 24bpp BGR payload bytes into 32-bit {8'h00,R,G,B} words, dropping row padding.
- Places each pixel at word address row*512+x, the layout the video scan-out reads back as cpu1 32-bit words.
- Buffers pixels in a small FIFO and issues them over a toggle req/ack handshake; reports load completion and errors.

Parameters:
- LINE_WORDS, 512: line pitch in 32-bit words; power of two.
- MAX_ROWS, 1024: rows kept; pixels in rows >= MAX_ROWS are dropped.
- FIFO_DEPTH, 4: pixel FIFO entries; power of two, >= 2.

Ports:
- clk_sys  in  1  system clock (clk_ram domain)
- reset_n  in  1  asynchronous active-low reset
- ioctl_download  in  1  download active
- ioctl_wr  in  1  byte strobe; may be high more than one cycle
- ioctl_addr  in  25  byte offset in the file
- ioctl_dout  in  8  byte value
- mem_req  out  1  toggle request
- mem_ack  in  1  toggle acknowledge
- mem_addr  out  22  32-bit word address
- mem_d  out  32  pixel word {8'h00,R,G,B}
- busy  out  1  high in HEADER, PIXELS or DRAIN
- bmp_loaded  out  1  high after a clean load
- bmp_error  out  1  sticky error flag
- img_width  out  16  header width, low 16 bits
- img_height  out  16  header height, low 16 bits

Behaviour:
- Reset: all outputs 0; FIFO empty; state IDLE.
- Byte acceptance: one byte per rising edge of ioctl_wr (edge-detected against a registered copy) while ioctl_download=1.
- Header capture, little-endian, by ioctl_addr: 10-13 data_offset (low 24 bits kept); 18-21 width; 22-25 height; 28-29 bpp.
- Header validation, performed on the byte at addr 29 and leading to ERROR on failure:
  - bpp != 24
  - width == 0
  - data_offset < 30
- States:
  - IDLE: rising edge of ioctl_download -> HEADER. Clears bmp_loaded, bmp_error and the pixel counters.
  - HEADER: after validation passes -> PIXELS. Bytes below data_offset are ignored.
  - PIXELS: bytes at addr >= data_offset form the payload in B,G,R order. The pixel is pushed on the cycle its R byte is accepted.
    - x runs 0..width-1; then padding bytes are discarded until the row byte count is a multiple of 4 (row_bytes = ceil(3*width/4)*4); then x=0, row+1.
    - Push only if x < LINE_WORDS and row < MAX_ROWS; otherwise drop silently.
    - mem_addr = row*LINE_WORDS + x, truncated to 22 bits.
  - DRAIN: entered on the falling edge of ioctl_download from PIXELS. Leaves when the FIFO is empty and mem_req == mem_ack.
  - DONE: bmp_loaded=1 unless bmp_error is set.
  - ERROR: all further bytes ignored. Falling edge of ioctl_download -> IDLE with bmp_error held.
  - A falling edge of ioctl_download while in HEADER -> ERROR.
  - A new rising edge of ioctl_download in DONE, ERROR or IDLE restarts (-> HEADER, flags cleared, FIFO flushed). An outstanding request is left to complete; no new request issues until mem_ack == mem_req.
- Handshake:
  - Idle when mem_req == mem_ack.
  - When idle and the FIFO is non-empty: pop the head, load mem_addr/mem_d, toggle mem_req, all on the same edge.
  - mem_addr and mem_d stay stable until mem_ack == mem_req.
  - Latency: a pixel pushed into an empty FIFO with the link idle raises its request 1 cycle after its R byte is accepted.
- FIFO:
  - Simultaneous push and pop is allowed.
  - A push into a full FIFO (without a pop in the same cycle) drops the pixel and sets bmp_error; loading continues.
- img_width and img_height update as their header bytes arrive.
- reset_n low mid-load aborts immediately, with all state as at reset. The memory side must clear mem_ack on the same reset.

Test Plan:
- Clean 2x2 load: offset 54, bpp 24, bytes 54-56 = 11,22,33, row stride 8; memory acks after 3 cycles -> words addr0=0x00332211, addr1 = pixel 2, addr512 = byte-62 pixel. Exactly 4 requests; bmp_loaded=1, bmp_error=0, img_width=2, img_height=2.
- Width 3 padding: 3x2 image -> 3 pad bytes per row dropped; second row pixel 0 written at addr 512, not at 3.
- bpp=32 header -> ERROR after byte 29, zero requests, bmp_error=1, bmp_loaded=0. A following valid download clears bmp_error and loads normally.
- Backpressure: mem_ack held for 40 cycles while bytes arrive every 2 cycles -> FIFO fills; overflow sets bmp_error. With 8-cycle ack and 12-cycle byte spacing, no error occurs and addresses stay strictly sequential.
- Width 600: pixels x >= 512 are not written; row 1 starts at addr 512.
- reset_n pulsed low mid-PIXELS with a request outstanding -> all outputs 0 asynchronously, state IDLE. The next download starts with mem_req=0 and completes cleanly.

Source files
------------

// File: rtl/bmp_pixel_loader.sv
// bmp_pixel_loader
//   Parses a 24bpp BMP arriving on the data_io ioctl byte stream and writes
//   each pixel as a {8'h00,R,G,B} word to SDRAM port 1 at row*LINE_WORDS+x.
//   Row padding is dropped. Pixels queue in a small FIFO and leave over a
//   toggle req/ack link.
// Ports:
//   clk_sys, reset_n           clock, async active-low reset
//   ioctl_download/wr/addr/dout byte stream from data_io
//   mem_req/mem_ack            toggle handshake (idle when equal)
//   mem_addr/mem_d             word address / pixel word, held while busy
//   busy, bmp_loaded, bmp_error load status
//   img_width, img_height      header dimensions (low 16 bits)
module bmp_pixel_loader #(
  parameter int LINE_WORDS = 512,
  parameter int MAX_ROWS   = 1024,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [21:0] mem_addr,
  output logic [31:0] mem_d,
  output logic        busy,
  output logic        bmp_loaded,
  output logic        bmp_error,
  output logic [15:0] img_width,
  output logic [15:0] img_height
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = 54;  // {addr[21:0], data[31:0]}

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_PIXELS, S_DRAIN, S_DONE, S_ERROR
  } state_t;

  state_t state_q, state_d;

  logic        wr_q, dl_q;
  logic        byte_stb, dl_rise, dl_fall, restart;
  logic        hdr_byte, hdr_last, hdr_bad, pay_byte;

  logic [23:0] off_q, off_d;
  logic [31:0] width_q, width_d;
  logic [15:0] height_q, height_d;
  logic [7:0]  bpp_lo_q, bpp_lo_d;
  logic [31:0] x_q, x_d, row_q, row_d;
  logic [1:0]  phase_q, phase_d;   // 0:B 1:G 2:R within a pixel
  logic [1:0]  bmod_q, bmod_d;     // bytes into current row, mod 4
  logic [7:0]  b_q, b_d, g_q, g_d;
  logic        error_q, error_d;

  logic [FIFO_DEPTH-1:0][EW-1:0] fifo_q, fifo_d;
  logic [PW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic        fifo_empty, fifo_full, push, push_ok, pop, link_idle;
  logic [21:0] lin_addr;

  logic        mem_req_q, mem_req_d;
  logic [21:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_d_q, mem_d_d;

  // ioctl_wr may stay high for several cycles; only its rising edge counts
  assign byte_stb = ioctl_download & ioctl_wr & ~wr_q;
  assign dl_rise  = ioctl_download & ~dl_q;
  assign dl_fall  = ~ioctl_download & dl_q;
  assign restart  = dl_rise & ((state_q == S_IDLE) | (state_q == S_DONE) |
                               (state_q == S_ERROR));

  assign hdr_byte = byte_stb & (state_q == S_HEADER);
  assign hdr_last = hdr_byte & (ioctl_addr == 25'd29);
  // width and offset are complete by byte 29; bpp high byte is on the bus now
  assign hdr_bad  = ({ioctl_dout, bpp_lo_q} != 16'd24) | (width_q == 32'd0) |
                    (off_q < 24'd30);
  assign pay_byte = byte_stb & (state_q == S_PIXELS) &
                    (ioctl_addr >= {1'b0, off_q});

  assign push     = pay_byte & (phase_q == 2'd2) & (x_q < width_q) &
                    (x_q < 32'(LINE_WORDS)) & (row_q < 32'(MAX_ROWS));
  assign lin_addr = 22'(row_q * 32'(LINE_WORDS) + x_q);

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[PW] != rptr_q[PW]) &
                      (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign link_idle  = (mem_req_q == mem_ack);
  // a restart flushes the FIFO, so nothing is popped on that edge
  assign pop        = link_idle & ~fifo_empty & ~restart;
  assign push_ok    = push & (~fifo_full | pop);

  // ---------------- state register ----------------
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // ---------------- next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (dl_rise) state_d = S_HEADER;
      S_ERROR: begin
        if (dl_rise)      state_d = S_HEADER;
        else if (dl_fall) state_d = S_IDLE;
      end
      S_HEADER: begin
        if (dl_fall)       state_d = S_ERROR;
        else if (hdr_last) state_d = hdr_bad ? S_ERROR : S_PIXELS;
      end
      S_PIXELS: if (dl_fall) state_d = S_DRAIN;
      S_DRAIN:  if (fifo_empty && link_idle) state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------- state outputs ----------------
  always_comb begin
    busy       = 1'b0;
    bmp_loaded = 1'b0;
    case (state_q)
      S_HEADER, S_PIXELS, S_DRAIN: busy = 1'b1;
      S_DONE:                      bmp_loaded = ~error_q;
      default: ;
    endcase
  end

  // ---------------- header, pixel unpacking, error ----------------
  always_comb begin
    off_d    = off_q;
    width_d  = width_q;
    height_d = height_q;
    bpp_lo_d = bpp_lo_q;
    x_d      = x_q;
    row_d    = row_q;
    phase_d  = phase_q;
    bmod_d   = bmod_q;
    b_d      = b_q;
    g_d      = g_q;
    error_d  = error_q;

    if (restart) begin
      error_d = 1'b0;
      x_d     = '0;
      row_d   = '0;
      phase_d = '0;
      bmod_d  = '0;
    end

    if (hdr_byte) begin
      case (ioctl_addr)
        25'd10: off_d[7:0]      = ioctl_dout;
        25'd11: off_d[15:8]     = ioctl_dout;
        25'd12: off_d[23:16]    = ioctl_dout;
        25'd18: width_d[7:0]    = ioctl_dout;
        25'd19: width_d[15:8]   = ioctl_dout;
        25'd20: width_d[23:16]  = ioctl_dout;
        25'd21: width_d[31:24]  = ioctl_dout;
        25'd22: height_d[7:0]   = ioctl_dout;
        25'd23: height_d[15:8]  = ioctl_dout;
        25'd28: bpp_lo_d        = ioctl_dout;
        default: ;
      endcase
    end

    if ((hdr_last && hdr_bad) || (state_q == S_HEADER && dl_fall))
      error_d = 1'b1;

    if (pay_byte) begin
      bmod_d = bmod_q + 2'd1;
      if (x_q < width_q) begin
        case (phase_q)
          2'd0:    begin b_d = ioctl_dout; phase_d = 2'd1; end
          2'd1:    begin g_d = ioctl_dout; phase_d = 2'd2; end
          default: begin
            phase_d = 2'd0;
            x_d     = x_q + 32'd1;
            // last pixel already ends on a 4-byte boundary: no padding
            if ((x_q + 32'd1 == width_q) && (bmod_q == 2'd3)) begin
              x_d   = '0;
              row_d = row_q + 32'd1;
            end
          end
        endcase
      end else if (bmod_q == 2'd3) begin
        // last padding byte of the row
        x_d   = '0;
        row_d = row_q + 32'd1;
      end
    end

    if (push && fifo_full && !pop) error_d = 1'b1;
  end

  // ---------------- FIFO and request link ----------------
  always_comb begin
    fifo_d     = fifo_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    mem_d_d    = mem_d_q;

    if (push_ok) begin
      fifo_d[wptr_q[PW-1:0]] = {lin_addr, 8'h00, ioctl_dout, g_q, b_q};
      wptr_d = wptr_q + (PW+1)'(1);
    end
    if (pop) begin
      {mem_addr_d, mem_d_d} = fifo_q[rptr_q[PW-1:0]];
      mem_req_d = ~mem_req_q;
      rptr_d    = rptr_q + (PW+1)'(1);
    end
    if (restart) begin
      wptr_d = '0;
      rptr_d = '0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_q       <= 1'b0;
      dl_q       <= 1'b0;
      off_q      <= '0;
      width_q    <= '0;
      height_q   <= '0;
      bpp_lo_q   <= '0;
      x_q        <= '0;
      row_q      <= '0;
      phase_q    <= '0;
      bmod_q     <= '0;
      b_q        <= '0;
      g_q        <= '0;
      error_q    <= 1'b0;
      fifo_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_d_q    <= '0;
    end else begin
      wr_q       <= ioctl_wr;
      dl_q       <= ioctl_download;
      off_q      <= off_d;
      width_q    <= width_d;
      height_q   <= height_d;
      bpp_lo_q   <= bpp_lo_d;
      x_q        <= x_d;
      row_q      <= row_d;
      phase_q    <= phase_d;
      bmod_q     <= bmod_d;
      b_q        <= b_d;
      g_q        <= g_d;
      error_q    <= error_d;
      fifo_q     <= fifo_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      mem_d_q    <= mem_d_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_d      = mem_d_q;
  assign bmp_error  = error_q;
  assign img_width  = width_q[15:0];
  assign img_height = height_q;

endmodule

// File: tb/tb_bmp_pixel_loader.sv
// Bench for bmp_pixel_loader: builds BMP files with random payload, streams
// them over ioctl, acks requests with a configurable delay and compares the
// written words against an index-based model of the BMP pixel layout.
module tb_bmp_pixel_loader;
  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic [21:0] mem_addr;
  logic [31:0] mem_d;
  logic        busy, bmp_loaded, bmp_error;
  logic [15:0] img_width, img_height;

  int total = 0;
  int bad   = 0;
  int ack_delay = 3;
  int ack_cnt = 0;

  logic [21:0] log_a[$];
  logic [31:0] log_d[$];
  logic [21:0] exp_a[$];
  logic [31:0] exp_d[$];
  logic [7:0]  file[$];

  always #5 clk_sys = ~clk_sys;

  bmp_pixel_loader dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr), .mem_d(mem_d),
    .busy(busy), .bmp_loaded(bmp_loaded), .bmp_error(bmp_error),
    .img_width(img_width), .img_height(img_height)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // memory side: logs each request when first seen, acks after ack_delay cycles
  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mem_ack <= 1'b0;
      ack_cnt <= 0;
    end else if (mem_req !== mem_ack) begin
      if (ack_cnt == 0) begin
        log_a.push_back(mem_addr);
        log_d.push_back(mem_d);
      end else begin
        chk("req_stable", 64'({mem_addr, mem_d}), 64'({log_a[$], log_d[$]}));
      end
      if (ack_cnt >= ack_delay - 1) begin
        mem_ack <= mem_req;
        ack_cnt <= 0;
      end else begin
        ack_cnt <= ack_cnt + 1;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic build(input int w, input int h, input int bpp, input int off);
    int stride = ((3 * w + 3) / 4) * 4;
    file.delete();
    for (int i = 0; i < off + h * stride; i++) file.push_back(8'($urandom));
    for (int k = 0; k < 4; k++) begin
      file[10 + k] = 8'(off >> (8 * k));
      file[18 + k] = 8'(w >> (8 * k));
      file[22 + k] = 8'(h >> (8 * k));
    end
    file[28] = 8'(bpp);
    file[29] = 8'(bpp >> 8);
  endtask

  // pixel (x,r) lives at file offset off + r*stride + 3x as B,G,R
  task automatic model(input int w, input int h, input int off);
    int stride = ((3 * w + 3) / 4) * 4;
    int p;
    exp_a.delete();
    exp_d.delete();
    for (int r = 0; r < h; r++)
      for (int x = 0; x < w; x++)
        if (x < 512 && r < 1024) begin
          p = off + r * stride + 3 * x;
          exp_a.push_back(22'(r * 512 + x));
          exp_d.push_back({8'h00, file[p + 2], file[p + 1], file[p]});
        end
  endtask

  task automatic send_byte(input int a, input int hold, input int gap);
    ioctl_addr = 25'(a);
    ioctl_dout = file[a];
    ioctl_wr   = 1'b1;
    step(hold);
    ioctl_wr   = 1'b0;
    step(gap);
  endtask

  task automatic send_range(input int lo, input int hi, input int hold, input int gap);
    for (int i = lo; i < hi; i++) send_byte(i, hold, gap);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 4000 && busy; i++) step(1);
    chk("drain_timeout", 64'(busy), 64'(0));
    step(2);
  endtask

  task automatic download(input int hold, input int gap);
    log_a.delete();
    log_d.delete();
    ioctl_download = 1'b1;
    step(2);
    send_range(0, file.size(), hold, gap);
    ioctl_download = 1'b0;
    wait_idle();
  endtask

  task automatic cmp_log(input string tag);
    int n = (log_a.size() < exp_a.size()) ? log_a.size() : exp_a.size();
    chk({tag, "_nreq"}, 64'(log_a.size()), 64'(exp_a.size()));
    for (int i = 0; i < n; i++)
      chk(tag, 64'({log_a[i], log_d[i]}), 64'({exp_a[i], exp_d[i]}));
  endtask

  task automatic chk_clean(input string tag, input int w, input int h);
    chk({tag, "_loaded"}, 64'(bmp_loaded), 64'(1));
    chk({tag, "_error"},  64'(bmp_error),  64'(0));
    chk({tag, "_width"},  64'(img_width),  64'(w));
    chk({tag, "_height"}, 64'(img_height), 64'(h));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req"},  64'(mem_req),    64'(0));
    chk({tag, "_addr"}, 64'(mem_addr),   64'(0));
    chk({tag, "_d"},    64'(mem_d),      64'(0));
    chk({tag, "_busy"}, 64'(busy),       64'(0));
    chk({tag, "_ld"},   64'(bmp_loaded), 64'(0));
    chk({tag, "_err"},  64'(bmp_error),  64'(0));
    chk({tag, "_w"},    64'(img_width),  64'(0));
    chk({tag, "_h"},    64'(img_height), 64'(0));
  endtask

  initial begin
    // reset state
    step(3);
    chk_reset_outs("rst");
    reset_n = 1'b1;
    step(2);
    chk_reset_outs("rst_rel");

    // clean 2x2 load with first-request latency check
    ack_delay = 3;
    build(2, 2, 24, 54);
    file[54] = 8'h11; file[55] = 8'h22; file[56] = 8'h33;
    model(2, 2, 54);
    log_a.delete(); log_d.delete();
    ioctl_download = 1'b1;
    step(2);
    chk("busy_hdr", 64'(busy), 64'(1));
    send_range(0, 56, 1, 1);
    send_byte(56, 1, 0);
    chk("lat_pre", 64'(mem_req), 64'(0));
    step(1);
    chk("lat_req", 64'(mem_req), 64'(1));
    chk("lat_addr", 64'(mem_addr), 64'(0));
    send_range(57, file.size(), 1, 1);
    ioctl_download = 1'b0;
    wait_idle();
    cmp_log("c2x2");
    chk("c2x2_px0", 64'(log_d[0]), 64'(32'h00332211));
    chk_clean("c2x2", 2, 2);

    // width 3: three pad bytes per row
    ack_delay = 2;
    build(3, 2, 24, 54);
    model(3, 2, 54);
    download(1, 1);
    cmp_log("w3");
    chk("w3_row1", 64'(log_a[3]), 64'(512));
    chk_clean("w3", 3, 2);

    // bpp=32 header -> error, then a valid load clears it
    build(2, 2, 32, 54);
    log_a.delete(); log_d.delete();
    ioctl_download = 1'b1;
    step(2);
    send_range(0, 30, 1, 1);
    step(1);
    chk("bpp_err_now", 64'(bmp_error), 64'(1));
    chk("bpp_busy", 64'(busy), 64'(0));
    send_range(30, file.size(), 1, 1);
    ioctl_download = 1'b0;
    wait_idle();
    chk("bpp_nreq", 64'(log_a.size()), 64'(0));
    chk("bpp_err", 64'(bmp_error), 64'(1));
    chk("bpp_ld", 64'(bmp_loaded), 64'(0));
    build(2, 1, 24, 60);
    model(2, 1, 60);
    log_a.delete(); log_d.delete();
    ioctl_download = 1'b1;
    step(2);
    chk("restart_err_clr", 64'(bmp_error), 64'(0));
    send_range(0, file.size(), 1, 1);
    ioctl_download = 1'b0;
    wait_idle();
    cmp_log("after_err");
    chk_clean("after_err", 2, 1);

    // backpressure overflow: long ack, fast bytes
    ack_delay = 40;
    build(4, 2, 24, 54);
    download(1, 1);
    chk("ovf_err", 64'(bmp_error), 64'(1));
    chk("ovf_ld", 64'(bmp_loaded), 64'(0));
    chk("ovf_dropped", 64'(log_a.size() < 8), 64'(1));

    // slow bytes with multi-cycle strobe: no error, sequential addresses
    ack_delay = 8;
    build(4, 2, 24, 54);
    model(4, 2, 54);
    download(2, 10);
    cmp_log("slow");
    chk_clean("slow", 4, 2);

    // width 600: x >= 512 dropped
    ack_delay = 2;
    build(600, 2, 24, 54);
    model(600, 2, 54);
    download(1, 1);
    cmp_log("w600");
    chk("w600_row1", 64'(log_a[512]), 64'(512));
    chk_clean("w600", 600, 2);

    // async reset mid-PIXELS with a request outstanding
    ack_delay = 40;
    build(4, 4, 24, 54);
    log_a.delete(); log_d.delete();
    ioctl_download = 1'b1;
    step(2);
    send_range(0, 63, 1, 1);
    chk("mid_req_out", 64'(mem_req != mem_ack), 64'(1));
    reset_n = 1'b0;
    ioctl_download = 1'b0;
    #2;
    chk_reset_outs("async");
    step(3);
    reset_n = 1'b1;
    step(2);
    chk("post_rst_ack", 64'(mem_ack), 64'(0));
    ack_delay = 3;
    build(2, 2, 24, 54);
    model(2, 2, 54);
    download(1, 1);
    cmp_log("post_rst");
    chk_clean("post_rst", 2, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
